// File: rtl/pgm_video_irq.sv
// PGM raster timing (ce_pix, hcount/vcount, blank/sync) and 68000 VBL/timer IPL generator; no backpressure.
// Counters move the clock after ce_pix, decodes lag 1 clock, event->ipl_n is 2 clocks; `PGM_TIMER_IRQ_EN adds the level-4 timer.
module pgm_video_irq #(
   parameter int CLK_DIV  = 3,
   parameter int H_TOTAL  = 568,
   parameter int H_ACTIVE = 448,
   parameter int HS_START = 460,
   parameter int HS_LEN   = 32,
   parameter int V_TOTAL  = 264,
   parameter int V_ACTIVE = 224,
   parameter int VS_START = 240,
   parameter int VS_LEN   = 3,
   parameter int TMR_LINE = 112
) (
   input  logic       fixed_20m_clk,
   input  logic       reset,
   output logic       ce_pix,
   output logic [9:0] hcount,
   output logic [8:0] vcount,
   output logic       hblank,
   output logic       vblank,
   output logic       hsync,
   output logic       vsync,
   input  logic       mask_we,
   input  logic [1:0] mask_din,
   input  logic       iack,
   input  logic [2:0] iack_level,
   output logic [2:0] ipl_n
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(HS_START);
   localparam logic [9:0] HS_END = 10'(HS_START + HS_LEN);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
   localparam logic [8:0] VS_BEG = 9'(VS_START);
   localparam logic [8:0] VS_END = 9'(VS_START + VS_LEN);
   // Line that precedes the interrupt line, accounting for a wrap into line 0.
   localparam logic [8:0] VBL_PREV = 9'((V_ACTIVE == 0) ? V_TOTAL - 1 : V_ACTIVE - 1);
   localparam logic [8:0] TMR_PREV = 9'((TMR_LINE == 0) ? V_TOTAL - 1 : TMR_LINE - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             ce_pix_q, ce_pix_d;
   logic [9:0]       hcount_q, hcount_d;
   logic [8:0]       vcount_q, vcount_d;
   logic             hblank_q, hblank_d;
   logic             vblank_q, vblank_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic [1:0]       mask_q, mask_d;
   logic             vbl_pend_q, vbl_pend_d;
   logic             tmr_pend_q, tmr_pend_d;
   logic [2:0]       ipl_n_q, ipl_n_d;

   logic pix_tick;
   logic line_end;
   logic vbl_evt;
   logic tmr_evt;
   logic vbl_clr;
   logic tmr_clr;

   always_comb begin
      pix_tick = (div_q == DIV_LAST);
      line_end = pix_tick && (hcount_q == H_LAST);
      vbl_evt  = line_end && (vcount_q == VBL_PREV);
      tmr_evt  = line_end && (vcount_q == TMR_PREV);

      div_d    = pix_tick ? '0 : div_q + 1'b1;
      ce_pix_d = (div_d == DIV_LAST);
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (pix_tick) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
         end else begin
            hcount_d = hcount_q + 1'b1;
         end
      end

      hblank_d = (hcount_q >= H_ACT);
      vblank_d = (vcount_q >= V_ACT);
      hsync_d  = (hcount_q >= HS_BEG) && (hcount_q < HS_END);
      vsync_d  = (vcount_q >= VS_BEG) && (vcount_q < VS_END);

      // The freshly written mask gates an event landing on the same cycle.
`ifdef PGM_TIMER_IRQ_EN
      mask_d = mask_we ? mask_din : mask_q;
`else
      mask_d = (mask_we ? mask_din : mask_q) & 2'b01;
`endif

      vbl_clr = (iack && (iack_level == 3'd6)) || (mask_we && !mask_din[0]);
      tmr_clr = (iack && (iack_level == 3'd4)) || (mask_we && !mask_din[1]);

      // Set dominates clear so an event is never dropped.
      vbl_pend_d = (vbl_evt && mask_d[0]) || (vbl_pend_q && !vbl_clr);
      tmr_pend_d = (tmr_evt && mask_d[1]) || (tmr_pend_q && !tmr_clr);

      if (vbl_pend_q) begin
         ipl_n_d = ~3'd6;
      end else if (tmr_pend_q) begin
         ipl_n_d = ~3'd4;
      end else begin
         ipl_n_d = 3'b111;
      end
   end

   always_ff @(posedge fixed_20m_clk) begin
      if (reset) begin
         div_q      <= '0;
         ce_pix_q   <= 1'b0;
         hcount_q   <= '0;
         vcount_q   <= '0;
         hblank_q   <= 1'b0;
         vblank_q   <= 1'b0;
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         mask_q     <= 2'b00;
         vbl_pend_q <= 1'b0;
         tmr_pend_q <= 1'b0;
         ipl_n_q    <= 3'b111;
      end else begin
         div_q      <= div_d;
         ce_pix_q   <= ce_pix_d;
         hcount_q   <= hcount_d;
         vcount_q   <= vcount_d;
         hblank_q   <= hblank_d;
         vblank_q   <= vblank_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         mask_q     <= mask_d;
         vbl_pend_q <= vbl_pend_d;
         tmr_pend_q <= tmr_pend_d;
         ipl_n_q    <= ipl_n_d;
      end
   end

   assign ce_pix = ce_pix_q;
   assign hcount = hcount_q;
   assign vcount = vcount_q;
   assign hblank = hblank_q;
   assign vblank = vblank_q;
   assign hsync  = hsync_q;
   assign vsync  = vsync_q;
   assign ipl_n  = ipl_n_q;

endmodule

// File: tb/tb_pgm_video_irq.sv
// Randomized bench for pgm_video_irq against an arithmetic model of raster position and interrupt state.
module tb_pgm_video_irq;
   localparam int CD  = 3;
   localparam int HT  = 40;
   localparam int HA  = 30;
   localparam int HSS = 32;
   localparam int HSL = 4;
   localparam int VT  = 20;
   localparam int VA  = 14;
   localparam int VSS = 16;
   localparam int VSL = 2;
   localparam int TL  = 7;
   localparam int FRAME = CD * HT * VT;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mask_we = 1'b0;
   logic [1:0] mask_din = 2'b00;
   logic       iack = 1'b0;
   logic [2:0] iack_level = 3'd0;
   logic       ce_pix;
   logic [9:0] hcount;
   logic [8:0] vcount;
   logic       hblank, vblank, hsync, vsync;
   logic [2:0] ipl_n;

   pgm_video_irq #(
      .CLK_DIV(CD), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_LEN(HSL),
      .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_LEN(VSL), .TMR_LINE(TL)
   ) dut (
      .fixed_20m_clk(clk),
      .reset(reset),
      .ce_pix(ce_pix),
      .hcount(hcount),
      .vcount(vcount),
      .hblank(hblank),
      .vblank(vblank),
      .hsync(hsync),
      .vsync(vsync),
      .mask_we(mask_we),
      .mask_din(mask_din),
      .iack(iack),
      .iack_level(iack_level),
      .ipl_n(ipl_n)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: cycle index since reset release plus the architectural interrupt state.
   int         m_k = 0;
   logic [1:0] m_mask = 2'b00;
   bit         m_vbl = 1'b0;
   bit         m_tmr = 1'b0;
   logic [2:0] m_ipl = 3'b111;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int hc(input int k);
      return (k / CD) % HT;
   endfunction

   function automatic int vc(input int k);
      return (k / (CD * HT)) % VT;
   endfunction

   // True when cycle k is the pixel tick that moves the raster onto column 0 of the given line.
   function automatic bit evt_into(input int k, input int line);
      int p;
      if (k % CD != CD - 1) return 1'b0;
      p = k / CD + 1;
      return (p % HT == 0) && ((p / HT) % VT == line);
   endfunction

   task automatic check_outputs();
      int pk;
      pk = (m_k == 0) ? 0 : m_k - 1;
      check("ce_pix", 32'(ce_pix), 32'(m_k % CD == CD - 1));
      check("hcount", 32'(hcount), 32'(hc(m_k)));
      check("vcount", 32'(vcount), 32'(vc(m_k)));
      check("hblank", 32'(hblank), 32'(hc(pk) >= HA));
      check("vblank", 32'(vblank), 32'(vc(pk) >= VA));
      check("hsync", 32'(hsync), 32'(hc(pk) >= HSS && hc(pk) < HSS + HSL));
      check("vsync", 32'(vsync), 32'(vc(pk) >= VSS && vc(pk) < VSS + VSL));
      check("ipl_n", 32'(ipl_n), 32'(m_ipl));
   endtask

   // Advance the model across one edge using the inputs currently applied, then compare.
   task automatic tick();
      logic [1:0] nmask;
      bit vev, tev, vclr, tclr;
      if (reset) begin
         m_k = 0; m_mask = 2'b00; m_vbl = 1'b0; m_tmr = 1'b0; m_ipl = 3'b111;
      end else begin
         nmask = mask_we ? mask_din : m_mask;
`ifndef PGM_TIMER_IRQ_EN
         nmask[1] = 1'b0;
`endif
         vev  = evt_into(m_k, VA);
         tev  = evt_into(m_k, TL);
         vclr = (iack && iack_level == 3'd6) || (mask_we && !mask_din[0]);
         tclr = (iack && iack_level == 3'd4) || (mask_we && !mask_din[1]);
         m_ipl = m_vbl ? 3'b001 : (m_tmr ? 3'b011 : 3'b111);
         if (vev && nmask[0]) m_vbl = 1'b1;
         else if (vclr)       m_vbl = 1'b0;
         if (tev && nmask[1]) m_tmr = 1'b1;
         else if (tclr)       m_tmr = 1'b0;
         m_mask = nmask;
         m_k++;
      end
      @(posedge clk);
      #1;
      mask_we = 1'b0;
      iack = 1'b0;
      check_outputs();
   endtask

   task automatic run_to_evt(input int line);
      bit found;
      found = 1'b0;
      for (int i = 0; i < FRAME + CD; i++) begin
         if (evt_into(m_k, line)) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("evt_bound", 32'(found), 32'd1);
   endtask

   task automatic run_to_line(input int line);
      bit found;
      found = 1'b0;
      for (int i = 0; i < FRAME + CD; i++) begin
         if (vc(m_k) == line) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("line_bound", 32'(found), 32'd1);
   endtask

   task automatic write_mask(input logic [1:0] v);
      mask_we = 1'b1;
      mask_din = v;
      tick();
   endtask

   task automatic ack(input logic [2:0] lvl);
      iack = 1'b1;
      iack_level = lvl;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      check("rst_ipl_n", 32'(ipl_n), 32'h7);
      check("rst_hcount", 32'(hcount), 32'h0);
      reset = 1'b0;

      // Masked frame: nothing may be raised.
      repeat (FRAME) tick();
      check("mask00_ipl", 32'(ipl_n), 32'h7);

      write_mask(2'b01);
      run_to_evt(VA);
      tick();
      check("vbl_lat1", 32'(ipl_n), 32'h7);
      tick();
      check("vbl_lat2", 32'(ipl_n), 32'h1);
      ack(3'd6);
      check("ack6_lat1", 32'(ipl_n), 32'h1);
      tick();
      check("ack6_lat2", 32'(ipl_n), 32'h7);

      // Acknowledge racing the next event: the new event must survive.
      run_to_evt(VA);
      ack(3'd6);
      tick();
      check("ack_vs_evt", 32'(ipl_n), 32'h1);

      // Reset inside vblank with an interrupt still pending.
      run_to_line(VA + 3);
      check("pre_rst_ipl", 32'(ipl_n), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_ipl", 32'(ipl_n), 32'h7);
      check("midrst_vcount", 32'(vcount), 32'h0);
      run_to_evt(VA);
      tick();
      tick();
      check("midrst_mask", 32'(ipl_n), 32'h7);

      write_mask(2'b11);
      run_to_evt(TL);
      tick();
      tick();
`ifdef PGM_TIMER_IRQ_EN
      check("tmr_ipl", 32'(ipl_n), 32'h3);
      run_to_evt(VA);
      tick();
      tick();
      check("vbl_over_tmr", 32'(ipl_n), 32'h1);
      ack(3'd6);
      tick();
      check("ack6_to_tmr", 32'(ipl_n), 32'h3);
      ack(3'd4);
      tick();
      check("ack4_idle", 32'(ipl_n), 32'h7);
`else
      check("no_tmr_ipl", 32'(ipl_n), 32'h7);
      run_to_evt(VA);
      tick();
      tick();
      check("vbl_only", 32'(ipl_n), 32'h1);
      ack(3'd4);
      tick();
      check("ack4_ignored", 32'(ipl_n), 32'h1);
      ack(3'd6);
      tick();
      check("ack6_idle", 32'(ipl_n), 32'h7);
`endif

      // Random traffic: occasional mask writes and acks, biased onto event cycles.
      for (int i = 0; i < 3 * FRAME; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            mask_we = 1'b1;
            mask_din = 2'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 24) == 0 || (evt_into(m_k, VA) && $urandom_range(0, 1) == 1)) begin
            iack = 1'b1;
            iack_level = 3'($urandom_range(0, 7));
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
